phase_demod: RTL and testbench

- Symbol-level demodulator for the {sign, phase} carrier scheme. The modulator produces one symbol per SAMPLES_PER_SYM carrier samples: phase selects sine (0) or cosine (1) carrier, and sign inverts it.
- Sits on the receive path. It consumes the signed sample stream, correlates each symbol window against square-wave sine and cosine references, and emits the decided 2-bit symbol with a one-cycle valid strobe.

---
 rtl/phase_demod_pkg.sv | 39 +++
 rtl/phase_demod_corr_acc.sv | 43 ++++
 rtl/phase_demod.sv | 143 ++++++++++++++
 tb/tb_phase_demod.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/phase_demod_pkg.sv
// phase_demod_pkg: shared constants for the {sign, phase} symbol demodulator.
//   - Reference quadrant boundaries derived from the symbol length.
//   - Default accumulator width.
//   - Symbol phase encoding (SIN / COS).
package phase_demod_pkg;

    localparam int unsigned DEF_SAMPLE_W        = 8;
    localparam int unsigned DEF_SAMPLES_PER_SYM = 64;

    // Sample width + log2(samples) growth + one bit for the sign.
    function automatic int unsigned acc_width(input int unsigned sample_w,
                                              input int unsigned n);
        return sample_w + $clog2(n) + 1;
    endfunction

    localparam int unsigned ACC_W = acc_width(DEF_SAMPLE_W, DEF_SAMPLES_PER_SYM);

    // ref_s flips sign at N/2; ref_c is negative over [N/4, 3N/4).
    function automatic int unsigned ref_q1(input int unsigned n);
        return n / 4;
    endfunction

    function automatic int unsigned ref_half(input int unsigned n);
        return n / 2;
    endfunction

    function automatic int unsigned ref_q3(input int unsigned n);
        return (3 * n) / 4;
    endfunction

    localparam int unsigned REF_Q1   = ref_q1(DEF_SAMPLES_PER_SYM);
    localparam int unsigned REF_HALF = ref_half(DEF_SAMPLES_PER_SYM);
    localparam int unsigned REF_Q3   = ref_q3(DEF_SAMPLES_PER_SYM);

    // Symbol phase encoding.
    localparam logic SIN = 1'b0;
    localparam logic COS = 1'b1;

endpackage

// File: rtl/phase_demod_corr_acc.sv
// corr_acc: one correlator arm. Multiplies the signed sample by +1/-1 and
// accumulates it, or loads the product to start a new window.
//   i_clk, i_rst_n  clock, async active-low reset
//   i_sample        signed input sample
//   i_en            accumulate/load this cycle
//   i_load          replace the accumulator with this product (window start)
//   i_neg           reference is -1 for this sample
//   o_acc_next      next-state accumulator value (includes this product)
module corr_acc #(
    parameter int unsigned SAMPLE_W = 8,
    parameter int unsigned ACC_W    = 15
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic signed [SAMPLE_W-1:0] i_sample,
    input  logic                       i_en,
    input  logic                       i_load,
    input  logic                       i_neg,
    output logic signed [ACC_W-1:0]    o_acc_next
);

    logic signed [ACC_W-1:0] r_acc;
    logic signed [ACC_W-1:0] w_ext;
    logic signed [ACC_W-1:0] w_prod;

    always_comb begin
        w_ext  = {{(ACC_W - SAMPLE_W){i_sample[SAMPLE_W-1]}}, i_sample};
        w_prod = i_neg ? -w_ext : w_ext;
        o_acc_next = r_acc;
        if (i_en) begin
            o_acc_next = i_load ? w_prod : r_acc + w_prod;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
        end else begin
            r_acc <= o_acc_next;
        end
    end

endmodule

// File: rtl/phase_demod.sv
// phase_demod: symbol-level demodulator for the {sign, phase} carrier scheme.
// Correlates each SAMPLES_PER_SYM window against square-wave sine and cosine
// references and emits the decided symbol with a one-cycle strobe.
//   clk, rst      clock, async active-low reset
//   sample_in     signed carrier sample, qualified by sample_valid
//   sym_start     resync: the valid sample this cycle is sample 0
//   sym_valid     one-cycle pulse when the decision outputs update
//   sym_sign      decided inversion (MSB of the winning correlation)
//   sym_phase     decided carrier, 0 = sine, 1 = cosine
//   low_energy    winning |correlation| below THRESH
//   sym_count     decided-symbol counter, wraps at 256
module phase_demod
    import phase_demod_pkg::*;
#(
    parameter int unsigned SAMPLE_W        = 8,
    parameter int unsigned SAMPLES_PER_SYM = 64,
    parameter int unsigned THRESH          = 256
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic signed [SAMPLE_W-1:0] sample_in,
    input  logic                       sample_valid,
    input  logic                       sym_start,
    output logic                       sym_valid,
    output logic                       sym_sign,
    output logic                       sym_phase,
    output logic                       low_energy,
    output logic [7:0]                 sym_count
);

    localparam int unsigned ACC_WIDTH = acc_width(SAMPLE_W, SAMPLES_PER_SYM);
    localparam int unsigned IDX_W     = $clog2(SAMPLES_PER_SYM);

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SAMPLES_PER_SYM - 1);
    localparam logic [IDX_W-1:0] IDX_Q1   = IDX_W'(ref_q1(SAMPLES_PER_SYM));
    localparam logic [IDX_W-1:0] IDX_HALF = IDX_W'(ref_half(SAMPLES_PER_SYM));
    localparam logic [IDX_W-1:0] IDX_Q3   = IDX_W'(ref_q3(SAMPLES_PER_SYM));

    localparam logic [ACC_WIDTH-1:0] THRESH_A = ACC_WIDTH'(THRESH);

    logic [IDX_W-1:0] r_idx;
    logic             r_sym_valid;
    logic             r_sym_sign;
    logic             r_sym_phase;
    logic             r_low_energy;
    logic [7:0]       r_sym_count;

    logic [IDX_W-1:0]            w_idx_cur;
    logic [IDX_W-1:0]            w_idx_next;
    logic                        w_load;
    logic                        w_last;
    logic                        w_neg_s;
    logic                        w_neg_c;
    logic signed [ACC_WIDTH-1:0] w_acc_s_next;
    logic signed [ACC_WIDTH-1:0] w_acc_c_next;
    logic [ACC_WIDTH-1:0]        w_mag_s;
    logic [ACC_WIDTH-1:0]        w_mag_c;
    logic [ACC_WIDTH-1:0]        w_win_mag;
    logic                        w_cos_wins;
    logic                        w_win_sign;

    // Index of the sample accepted this cycle; a resync forces it to 0.
    always_comb begin
        w_idx_cur  = sym_start ? '0 : r_idx;
        w_load     = sample_valid && (w_idx_cur == '0);
        // Resync wins over a would-be last sample: no decision then.
        w_last     = sample_valid && !sym_start && (r_idx == IDX_LAST);
        w_idx_next = (w_idx_cur == IDX_LAST) ? '0 : w_idx_cur + IDX_W'(1);
    end

    // Square-wave references, expressed as "multiply by -1" flags.
    always_comb begin
        w_neg_s = (w_idx_cur >= IDX_HALF);
        w_neg_c = (w_idx_cur >= IDX_Q1) && (w_idx_cur < IDX_Q3);
    end

    corr_acc #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_WIDTH)
    ) u_acc_s (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_sample   (sample_in),
        .i_en       (sample_valid),
        .i_load     (w_load),
        .i_neg      (w_neg_s),
        .o_acc_next (w_acc_s_next)
    );

    corr_acc #(
        .SAMPLE_W (SAMPLE_W),
        .ACC_W    (ACC_WIDTH)
    ) u_acc_c (
        .i_clk      (clk),
        .i_rst_n    (rst),
        .i_sample   (sample_in),
        .i_en       (sample_valid),
        .i_load     (w_load),
        .i_neg      (w_neg_c),
        .o_acc_next (w_acc_c_next)
    );

    // Decision on next-state accumulators so the final products count.
    always_comb begin
        w_mag_s    = w_acc_s_next[ACC_WIDTH-1] ? ACC_WIDTH'(-w_acc_s_next)
                                               : ACC_WIDTH'(w_acc_s_next);
        w_mag_c    = w_acc_c_next[ACC_WIDTH-1] ? ACC_WIDTH'(-w_acc_c_next)
                                               : ACC_WIDTH'(w_acc_c_next);
        // Ties go to sine.
        w_cos_wins = (w_mag_c > w_mag_s);
        w_win_mag  = w_cos_wins ? w_mag_c : w_mag_s;
        w_win_sign = w_cos_wins ? w_acc_c_next[ACC_WIDTH-1] : w_acc_s_next[ACC_WIDTH-1];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_idx        <= '0;
            r_sym_valid  <= 1'b0;
            r_sym_sign   <= 1'b0;
            r_sym_phase  <= SIN;
            r_low_energy <= 1'b0;
            r_sym_count  <= 8'd0;
        end else begin
            r_sym_valid <= w_last;
            if (sample_valid) begin
                r_idx <= w_idx_next;
            end
            if (w_last) begin
                r_sym_sign   <= w_win_sign;
                r_sym_phase  <= w_cos_wins ? COS : SIN;
                r_low_energy <= (w_win_mag < THRESH_A);
                r_sym_count  <= r_sym_count + 8'd1;
            end
        end
    end

    assign sym_valid  = r_sym_valid;
    assign sym_sign   = r_sym_sign;
    assign sym_phase  = r_sym_phase;
    assign low_energy = r_low_energy;
    assign sym_count  = r_sym_count;

endmodule

// File: tb/tb_phase_demod.sv
module tb_phase_demod;

    logic              clk;
    logic              rst;
    logic signed [7:0] sample_in;
    logic              sample_valid;
    logic              sym_start;
    logic              sym_valid;
    logic              sym_sign;
    logic              sym_phase;
    logic              low_energy;
    logic [7:0]        sym_count;

    int        n_cmp = 0;
    int        n_err = 0;
    logic [7:0] exp_count = 8'd0;

    phase_demod dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .sym_start    (sym_start),
        .sym_valid    (sym_valid),
        .sym_sign     (sym_sign),
        .sym_phase    (sym_phase),
        .low_energy   (low_energy),
        .sym_count    (sym_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Modulator model: sign inverts, phase picks sine (0) or cosine (1).
    function automatic logic signed [7:0] samp(input logic sgn, input logic ph,
                                               input int amp, input int i);
        int r;
        if (!ph) r = (i < 32) ? amp : -amp;
        else     r = (i < 16 || i >= 48) ? amp : -amp;
        if (sgn) r = -r;
        return 8'(r);
    endfunction

    // Inputs applied at a negedge, consumed by the next posedge, observed at
    // the following negedge.
    task automatic tick(input logic signed [7:0] s, input logic v, input logic st);
        sample_in    = s;
        sample_valid = v;
        sym_start    = st;
        @(negedge clk);
        sample_valid = 1'b0;
        sym_start    = 1'b0;
    endtask

    // Send one full symbol and check the decision right after the last sample.
    task automatic send_sym(input string nm, input logic sgn, input logic ph,
                            input int amp, input logic gap, input logic start,
                            input logic exp_low);
        int   pulses;
        logic exp_sign;
        logic exp_phase;
        pulses    = 0;
        exp_sign  = (amp != 0) ? sgn : 1'b0;
        exp_phase = (amp != 0) ? ph : 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick(samp(sgn, ph, amp, i), 1'b1, start && (i == 0));
            if (i < 63) begin
                if (sym_valid) pulses++;
                if (gap) begin
                    tick(8'sd0, 1'b0, 1'b0);
                    if (sym_valid) pulses++;
                end
            end
        end
        exp_count = exp_count + 8'd1;
        n_cmp++;
        if (pulses !== 0) begin
            n_err++;
            $display("FAIL %s early_pulses: got %0d want 0", nm, pulses);
        end
        n_cmp++;
        if (sym_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s sym_valid: got %b want 1", nm, sym_valid);
        end
        n_cmp++;
        if (sym_sign !== exp_sign) begin
            n_err++;
            $display("FAIL %s sym_sign: got %b want %b", nm, sym_sign, exp_sign);
        end
        n_cmp++;
        if (sym_phase !== exp_phase) begin
            n_err++;
            $display("FAIL %s sym_phase: got %b want %b", nm, sym_phase, exp_phase);
        end
        n_cmp++;
        if (low_energy !== exp_low) begin
            n_err++;
            $display("FAIL %s low_energy: got %b want %b", nm, low_energy, exp_low);
        end
        n_cmp++;
        if (sym_count !== exp_count) begin
            n_err++;
            $display("FAIL %s sym_count: got %0d want %0d", nm, sym_count, exp_count);
        end
    endtask

    task automatic test_reset();
        int pulses;
        pulses = 0;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick(8'($urandom), 1'($urandom), 1'($urandom));
            if (sym_valid) pulses++;
        end
        n_cmp++;
        if ({sym_valid, sym_sign, sym_phase, low_energy, sym_count} !== 12'd0 || pulses != 0) begin
            n_err++;
            $display("FAIL reset_outputs: got %b%b%b%b cnt=%0d pulses=%0d want all 0",
                     sym_valid, sym_sign, sym_phase, low_energy, sym_count, pulses);
        end
        rst = 1'b1;
        @(negedge clk);
        send_sym("reset_first", 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        tick(8'sd0, 1'b0, 1'b0);
        n_cmp++;
        if (sym_valid !== 1'b0) begin
            n_err++;
            $display("FAIL reset_single_pulse: got %b want 0", sym_valid);
        end
    endtask

    task automatic test_sine();
        send_sym("sine", 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        tick(8'sd0, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_sym("b2b_00", 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        send_sym("b2b_01", 1'b0, 1'b1, 100, 1'b0, 1'b0, 1'b0);
        send_sym("b2b_10", 1'b1, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        send_sym("b2b_11", 1'b1, 1'b1, 100, 1'b0, 1'b0, 1'b0);
        tick(8'sd0, 1'b0, 1'b0);
    endtask

    task automatic test_gaps_low_energy();
        send_sym("gap_low", 1'b0, 1'b0, 3, 1'b1, 1'b0, 1'b1);
        tick(8'sd0, 1'b0, 1'b0);
        n_cmp++;
        if (sym_valid !== 1'b0) begin
            n_err++;
            $display("FAIL gap_pulse_width: got %b want 0", sym_valid);
        end
    endtask

    task automatic test_resync();
        // Partial symbol of 40 samples, then resync on idx 40.
        for (int i = 0; i < 40; i++) tick(8'sd77, 1'b1, 1'b0);
        send_sym("resync_40", 1'b0, 1'b1, 100, 1'b0, 1'b1, 1'b0);
        // 63 samples, then resync lands on the would-be idx 63 sample.
        for (int i = 0; i < 63; i++) tick(-8'sd50, 1'b1, 1'b0);
        send_sym("resync_63", 1'b1, 1'b1, 100, 1'b0, 1'b1, 1'b0);
        // sym_start without sample_valid must not disturb the count.
        for (int i = 0; i < 10; i++) tick(8'sd9, 1'b1, 1'b0);
        tick(8'sd0, 1'b0, 1'b1);
        for (int i = 0; i < 54; i++) tick(8'sd9, 1'b1, 1'b0);
        n_cmp++;
        if (sym_valid !== 1'b1 || sym_count !== exp_count + 8'd1) begin
            n_err++;
            $display("FAIL start_no_valid: got v=%b cnt=%0d want v=1 cnt=%0d",
                     sym_valid, sym_count, exp_count + 8'd1);
        end
        exp_count = exp_count + 8'd1;
        tick(8'sd0, 1'b0, 1'b0);
    endtask

    task automatic test_mid_reset();
        send_sym("pre_reset", 1'b1, 1'b1, 100, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 30; i++) tick(8'sd100, 1'b1, 1'b0);
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({sym_valid, sym_sign, sym_phase, low_energy, sym_count} !== 12'd0) begin
            n_err++;
            $display("FAIL mid_reset_async: got s=%b p=%b cnt=%0d want 0",
                     sym_sign, sym_phase, sym_count);
        end
        @(negedge clk);
        rst = 1'b1;
        exp_count = 8'd0;
        @(negedge clk);
        send_sym("post_reset", 1'b0, 1'b1, 100, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_tie_wrap();
        send_sym("tie_zero", 1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b1);
        while (exp_count != 8'd255) begin
            send_sym("wrap_run", 1'b0, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        end
        send_sym("wrap_last", 1'b1, 1'b0, 100, 1'b0, 1'b0, 1'b0);
        n_cmp++;
        if (sym_count !== 8'd0) begin
            n_err++;
            $display("FAIL count_wrap: got %0d want 0", sym_count);
        end
    endtask

    initial begin
        rst          = 1'b0;
        sample_in    = 8'sd0;
        sample_valid = 1'b0;
        sym_start    = 1'b0;
        @(negedge clk);
        test_reset();
        test_sine();
        test_back_to_back();
        test_gaps_low_energy();
        test_resync();
        test_mid_reset();
        test_tie_wrap();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
